// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter (reverse double-dabble, 32 shift cycles).
// Optional macro BCD_CHECK_EN rejects inputs with any digit > 9 and raises err.
module bcd_to_binary (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] bcd_in,
   output logic [31:0] bin_out,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e      state_q, state_d;
   logic [31:0] digits_q, digits_d;
   logic [31:0] result_q, result_d;
   logic [31:0] bin_q, bin_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        check_fail;
   logic        copy_ok;
   logic [63:0] shifted;
   logic [31:0] adj_digits;

`ifdef BCD_CHECK_EN
   logic err_q, err_d;

   function automatic logic has_bad_digit(input logic [31:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (v[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   assign check_fail = has_bad_digit(bcd_in);
   // A rejected request must leave the previous result visible.
   assign copy_ok    = ~err_q;
   assign err        = err_q;
`else
   assign check_fail = 1'b0;
   assign copy_ok    = 1'b1;
   assign err        = 1'b0;
`endif

   always_comb begin
      shifted    = {digits_q, result_q} >> 1;
      adj_digits = shifted[63:32];
      for (int i = 0; i < 8; i++) begin
         if (adj_digits[4*i+3]) adj_digits[4*i +: 4] = adj_digits[4*i +: 4] - 4'd3;
      end
   end

   always_comb begin
      state_d  = state_q;
      digits_d = digits_q;
      result_d = result_q;
      bin_d    = bin_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef BCD_CHECK_EN
      err_d    = err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start && check_fail) begin
               state_d = StDone;
`ifdef BCD_CHECK_EN
               err_d   = 1'b1;
`endif
            end else if (start) begin
               digits_d = bcd_in;
               result_d = 32'd0;
               cnt_d    = 6'd32;
               busy_d   = 1'b1;
               state_d  = StShift;
`ifdef BCD_CHECK_EN
               err_d    = 1'b0;
`endif
            end
         end
         StShift: begin
            digits_d = adj_digits;
            result_d = shifted[31:0];
            cnt_d    = cnt_q - 6'd1;
            if (cnt_q == 6'd1) state_d = StDone;
         end
         StDone: begin
            // Two cycles in DONE: first raises the pulse, second returns to IDLE.
            if (!done_q) begin
               done_d = 1'b1;
               busy_d = 1'b0;
               if (copy_ok) bin_d = result_q;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         digits_q <= 32'd0;
         result_q <= 32'd0;
         bin_q    <= 32'd0;
         cnt_q    <= 6'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef BCD_CHECK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         digits_q <= digits_d;
         result_q <= result_d;
         bin_q    <= bin_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef BCD_CHECK_EN
         err_q    <= err_d;
`endif
      end
   end

   assign bin_out = bin_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: vector table, hand sequences, random vs decimal model.
module tb_bcd_to_binary;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] bcd_in;
   logic [31:0] bin_out;
   logic        busy;
   logic        done;
   logic        err;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   bcd_to_binary dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bcd_in  (bcd_in),
      .bin_out (bin_out),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   typedef struct {
      logic [31:0] bcd;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Decimal value of packed BCD digits, plain arithmetic.
   function automatic logic [31:0] bcd_value(input logic [31:0] v);
      longint unsigned acc;
      logic [31:0] t;
      acc = 0;
      t   = v;
      for (int i = 7; i >= 0; i--) acc = acc * 10 + longint'(t[4*i +: 4]);
      return 32'(acc);
   endfunction

   // Issue one conversion; glitch_at > 0 re-pulses start with 0x1 during that cycle.
   task automatic run_conv(input logic [31:0] bcd, input int glitch_at, output int lat,
                           output logic [31:0] res, output logic busy_gap);
      start    = 1'b1;
      bcd_in   = bcd;
      tick();
      start    = 1'b0;
      bcd_in   = $urandom;
      lat      = 99;
      busy_gap = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (c == glitch_at) begin
            start  = 1'b1;
            bcd_in = 32'h1;
         end
         tick();
         start = 1'b0;
         if (done) begin
            lat = c;
            break;
         end
         if (!busy) busy_gap = 1'b1;
      end
      res = bin_out;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [31:0] res;
      logic        gap;
      int          first_done;
      int          second_done;
      logic        seen;

      tbl[0] = '{32'h0000_1234, 32'h0000_04D2};
      tbl[1] = '{32'h9999_9999, 32'h05F5_E0FF};
      tbl[2] = '{32'h0000_0000, 32'h0000_0000};
      tbl[3] = '{32'h0000_0255, 32'h0000_00FF};
      tbl[4] = '{32'h0000_0042, 32'h0000_002A};
      tbl[5] = '{32'h0000_0001, 32'h0000_0001};
      tbl[6] = '{32'h1000_0000, 32'h0098_9680};
      tbl[7] = '{32'h1234_5678, 32'h00BC_614E};

      rst    = 1'b0;
      start  = 1'b0;
      bcd_in = 32'd0;
      #1 rst = 1'b1;
      tick();
      tick();
      check("reset_bin", bin_out, 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_err", 32'(err), 32'd0);
      rst = 1'b0;
      tick();

      foreach (tbl[i]) begin
         run_conv(tbl[i].bcd, 0, lat, res, gap);
         check("tbl_latency", 32'(lat), 32'd33);
         check("tbl_bin", res, tbl[i].exp);
         check("tbl_busy_gap", 32'(gap), 32'd0);
         check("tbl_err", 32'(err), 32'd0);
      end

      // Start during SHIFT is ignored and not queued.
      run_conv(32'h0000_0255, 10, lat, res, gap);
      check("glitch_latency", 32'(lat), 32'd33);
      check("glitch_bin", res, 32'h0000_00FF);
      check("glitch_busy_gap", 32'(gap), 32'd0);
      tick();
      check("glitch_not_queued_busy", 32'(busy), 32'd0);
      check("glitch_not_queued_done", 32'(done), 32'd0);

      // Start held high: conversions repeat every 35 cycles.
      start       = 1'b1;
      bcd_in      = 32'h0000_1234;
      first_done  = -1;
      second_done = -1;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (done) begin
            if (first_done < 0) first_done = c;
            else begin
               second_done = c;
               break;
            end
         end
      end
      start = 1'b0;
      check("held_period", 32'(second_done - first_done), 32'd35);
      check("held_bin", bin_out, 32'h0000_04D2);
      tick();
      tick();
      check("held_idle_busy", 32'(busy), 32'd0);

      // Reset mid-conversion aborts with no done pulse.
      start  = 1'b1;
      bcd_in = 32'h0000_9999;
      tick();
      start  = 1'b0;
      repeat (15) tick();
      rst = 1'b1;
      #1;
      check("abort_bin", bin_out, 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_err", 32'(err), 32'd0);
      tick();
      rst  = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (done || busy) seen = 1'b1;
      end
      check("abort_no_activity", 32'(seen), 32'd0);
      run_conv(32'h0000_0042, 0, lat, res, gap);
      check("post_abort_latency", 32'(lat), 32'd33);
      check("post_abort_bin", res, 32'h0000_002A);

`ifdef BCD_CHECK_EN
      run_conv(32'h0000_1234, 0, lat, res, gap);
      check("pre_invalid_bin", res, 32'h0000_04D2);
      start  = 1'b1;
      bcd_in = 32'h0000_001A;
      tick();
      start  = 1'b0;
      tick();
      check("invalid_done", 32'(done), 32'd1);
      check("invalid_err", 32'(err), 32'd1);
      check("invalid_bin_kept", bin_out, 32'h0000_04D2);
      tick();
      run_conv(32'h0000_0042, 0, lat, res, gap);
      check("err_cleared", 32'(err), 32'd0);
      check("after_invalid_bin", res, 32'h0000_002A);
`endif

      for (int n = 0; n < 24; n++) begin
         logic [31:0] v;
         for (int d = 0; d < 8; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
         run_conv(v, 0, lat, res, gap);
         check("rand_latency", 32'(lat), 32'd33);
         check("rand_bin", res, bcd_value(v));
         check("rand_err", 32'(err), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
